fifo_sp_ctrl: RTL and testbench
===============================

# fifo_sp_ctrl

FIFO controller that sits directly upstream of the single-port synchronous RAM `ram_sp_sr_sw` and turns it into a first-in/first-out buffer. It owns the read/write pointers and the occupancy count, arbitrates the RAM's single port between push and pop traffic, and returns popped words one cycle after acceptance. The RAM is instantiated alongside it; this block drives the RAM's `address`, `data_in`, `en` and `rnw`, and consumes its `data_out`.

## Interface
- `DATA_WIDTH`, 4, word width; must match the RAM.
- `ADDR_WIDTH`, 3, RAM address width; FIFO depth is DEPTH = 2^ADDR_WIDTH.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_L`  in  1  reset, synchronous, active-low.
- `push`  in  1  write request.
- `push_data`  in  DATA_WIDTH  word to enqueue.
- `push_ready`  out  1  push accepted this cycle if `push` && `push_ready`; combinational.
- `pop`  in  1  read request.
- `pop_ready`  out  1  pop accepted this cycle if `pop` && `pop_ready`; combinational.
- `pop_data`  out  DATA_WIDTH  dequeued word; equals `ram_data_out`.
- `pop_valid`  out  1  `pop_data` valid; registered.
- `empty`, `full`  out  1  each; registered, derived from count.
- `fifo_count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `err`  out  1  sticky: push while full or pop while empty.
- `ram_address`  out  ADDR_WIDTH  to RAM `address`.
- `ram_data_in`  out  DATA_WIDTH  to RAM `data_in`.
- `ram_en`  out  1  to RAM `en`.
- `ram_rnw`  out  1  to RAM `rnw` (1 = read, 0 = write).
- `ram_data_out`  in  DATA_WIDTH  from RAM `data_out`.

## Operation
- RAM contract:
  - Write on the rising edge when `en`=1 and `rnw`=0.
  - Read on the rising edge when `en`=1 and `rnw`=1; `data_out` is registered and holds until the next read.
- Ready logic:
  - `pop_ready` = !`empty`.
  - `push_ready` = !`full` && !(`pop` && `pop_ready`).
  - Pop has priority over push; one RAM access per cycle.
- Accepted pop:
  - `ram_en`=1, `ram_rnw`=1, `ram_address`=`rd_ptr`.
  - `rd_ptr` increments; count decrements.
- Accepted push:
  - `ram_en`=1, `ram_rnw`=0, `ram_address`=`wr_ptr`, `ram_data_in`=`push_data`.
  - `wr_ptr` increments; count increments.
- No accepted operation: `ram_en`=0, `ram_rnw`=1, `ram_address`=`rd_ptr`, `ram_data_in`=0.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH (7 → 0).
- Count is ADDR_WIDTH+1 bits.
- `empty` = (count==0); `full` = (count==DEPTH).
- Access state register, for debug: IDLE, WR, RD.
  - Next state is RD on an accepted pop, WR on an accepted push, otherwise IDLE.
  - `pop_valid` = (state==RD).
- `push` while `full`: push is ignored, `err` is set. `pop` while `empty`: pop is ignored, `err` is set.
  - A push that is stalled only because of pop priority is not an error.
- `err` clears only on reset.
- Reset (`reset_L`=0 at an edge):
  - `rd_ptr`=`wr_ptr`=0, count=0, state=IDLE.
  - Outputs: `empty`=1, `full`=0, `pop_valid`=0, `err`=0.
  - `ram_en` is forced to 0 while `reset_L`=0.
  - RAM contents are not cleared.
  - Reset mid-operation discards in-flight pops: `pop_valid` is 0 in the cycle after reset.

## Timing
- Push accepted in cycle N: word is in RAM after edge N. It is poppable from cycle N+1 (`empty` deasserts after edge N).
- Pop accepted in cycle N: `pop_valid`=1 and `pop_data` valid during cycle N+1. Throughput is 1 pop/cycle.
- Back-to-back push/pop to the same entry is legal; RAM write at edge N is visible to a read at edge N+1 or later.
- `full`, `empty` and `fifo_count` update on the edge following the accepted operation.
- Ready signals use the registered flags, so there is no combinational path from `push` to `push_ready`.

## Test plan
- Reset, then idle:
  - `empty`=1, `full`=0, `fifo_count`=0, `pop_valid`=0, `err`=0, `ram_en`=0.
- Push 15,14,…,8 on 8 consecutive cycles:
  - `fifo_count` goes 1..8; `full`=1 after the 8th.
  - RAM address sequence is 0..7 with `rnw`=0.
- From full, pop 8 consecutive cycles:
  - `pop_valid`=1 for 8 cycles, starting one cycle after the first pop.
  - `pop_data` = 15,14,…,8; `empty`=1 at the end.
- Push with `full`=1, then pop with `empty`=1:
  - Neither is accepted and count is unchanged.
  - `err`=1 and stays 1 until `reset_L`=0.
- With 3 entries, assert `push` and `pop` together for 2 cycles:
  - `push_ready`=0 and two words are popped.
  - With `pop` low, the push is then accepted; count goes 3→1→2.
- Wrap-around:
  - Push 8, pop 5, push 5: `wr_ptr` wraps to 5.
  - Popping 8 returns FIFO order across the 7→0 boundary.
- Assert `reset_L`=0 in the cycle after a pop: no `pop_valid`, and all flags return to reset values.

Source files
------------

// File: rtl/fifo_sp_ctrl.sv
// fifo_sp_ctrl: FIFO controller in front of a single-port synchronous RAM.
// Pop wins the RAM port over push; popped data returns one cycle later.
module fifo_sp_ctrl #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  push_ready,
   input  logic                  pop,
   output logic                  pop_ready,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_valid,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   fifo_count,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_en,
   output logic                  ram_rnw,
   input  logic [DATA_WIDTH-1:0] ram_data_out
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, WR, RD} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic [ADDR_WIDTH:0]   count_nxt;
   logic                  pop_acc;
   logic                  push_acc;

   // Ready terms use only registered flags plus pop, never push.
   assign pop_ready  = !empty;
   assign pop_acc    = pop && pop_ready;
   assign push_ready = !full && !pop_acc;
   assign push_acc   = push && push_ready;

   assign pop_data   = ram_data_out;
   assign pop_valid  = (state == RD);
   assign fifo_count = count;

   assign ram_en      = reset_L && (pop_acc || push_acc);
   assign ram_rnw     = !push_acc;
   assign ram_address = push_acc ? wr_ptr : rd_ptr;
   assign ram_data_in = push_acc ? push_data : '0;

   always_comb begin
      state_nxt = IDLE;
      count_nxt = count;
      unique case (1'b1)
         pop_acc: begin
            state_nxt = RD;
            count_nxt = count - CNT_ONE;
         end
         push_acc: begin
            state_nxt = WR;
            count_nxt = count + CNT_ONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state  <= IDLE;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == CNT_FULL);
         if (pop_acc)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (push_acc)
            wr_ptr <= wr_ptr + PTR_ONE;
         // A push held off only by pop priority is not an error.
         if ((push && full) || (pop && empty))
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_sp_ctrl.sv
// tb_fifo_sp_ctrl: directed bench for fifo_sp_ctrl with a behavioural
// single-port RAM attached to its RAM port.
module tb_fifo_sp_ctrl;

   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic       push = 1'b0;
   logic [3:0] push_data = '0;
   logic       push_ready;
   logic       pop = 1'b0;
   logic       pop_ready;
   logic [3:0] pop_data;
   logic       pop_valid;
   logic       empty;
   logic       full;
   logic [3:0] fifo_count;
   logic       err;
   logic [2:0] ram_address;
   logic [3:0] ram_data_in;
   logic       ram_en;
   logic       ram_rnw;
   logic [3:0] ram_data_out = '0;

   logic [3:0] mem [8];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_rnw)
            ram_data_out <= mem[ram_address];
         else
            mem[ram_address] <= ram_data_in;
      end
   end

   fifo_sp_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) dut (
      .clk(clk), .reset_L(reset_L),
      .push(push), .push_data(push_data), .push_ready(push_ready),
      .pop(pop), .pop_ready(pop_ready), .pop_data(pop_data),
      .pop_valid(pop_valid), .empty(empty), .full(full),
      .fifo_count(fifo_count), .err(err),
      .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_en(ram_en), .ram_rnw(ram_rnw), .ram_data_out(ram_data_out)
   );

   task automatic do_reset();
      @(negedge clk);
      push = 1'b0;
      pop = 1'b0;
      reset_L = 1'b0;
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   task automatic push_n(input int n, input logic [3:0] base);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         push = 1'b1;
         push_data = base + 4'(i);
      end
      @(negedge clk);
      push = 1'b0;
   endtask

   task automatic pop_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pop = 1'b1;
      end
      @(negedge clk);
      pop = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(posedge clk); #1;
      checks++;
      if (empty !== 1'b1) begin
         errors++; $display("FAIL rst_empty got %b exp 1", empty);
      end
      checks++;
      if (full !== 1'b0) begin
         errors++; $display("FAIL rst_full got %b exp 0", full);
      end
      checks++;
      if (fifo_count !== 4'd0) begin
         errors++; $display("FAIL rst_count got %0d exp 0", fifo_count);
      end
      checks++;
      if (pop_valid !== 1'b0) begin
         errors++; $display("FAIL rst_pop_valid got %b exp 0", pop_valid);
      end
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL rst_err got %b exp 0", err);
      end
      checks++;
      if (ram_en !== 1'b0) begin
         errors++; $display("FAIL rst_ram_en got %b exp 0", ram_en);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         push = 1'b1;
         push_data = 4'(15 - i);
         #1;
         checks++;
         if (ram_en !== 1'b1 || ram_rnw !== 1'b0 || ram_address !== 3'(i)) begin
            errors++;
            $display("FAIL fill_ram en %b rnw %b addr %0d exp 1 0 %0d",
                     ram_en, ram_rnw, ram_address, i);
         end
         @(posedge clk); #1;
         checks++;
         if (fifo_count !== 4'(i + 1) || full !== (i == 7)) begin
            errors++;
            $display("FAIL fill_count got %0d full %b exp %0d full %b",
                     fifo_count, full, i + 1, (i == 7));
         end
      end
      @(negedge clk);
      push = 1'b0;
   endtask

   task automatic test_drain();
      checks++;
      if (pop_valid !== 1'b0) begin
         errors++; $display("FAIL drain_pre_valid got %b exp 0", pop_valid);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         pop = 1'b1;
         #1;
         checks++;
         if (ram_en !== 1'b1 || ram_rnw !== 1'b1 || ram_address !== 3'(i)) begin
            errors++;
            $display("FAIL drain_ram en %b rnw %b addr %0d exp 1 1 %0d",
                     ram_en, ram_rnw, ram_address, i);
         end
         @(posedge clk); #1;
         checks++;
         if (pop_valid !== 1'b1 || pop_data !== 4'(15 - i)) begin
            errors++;
            $display("FAIL drain_data valid %b data %0d exp 1 %0d",
                     pop_valid, pop_data, 15 - i);
         end
      end
      @(negedge clk);
      pop = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (pop_valid !== 1'b0 || empty !== 1'b1 || fifo_count !== 4'd0) begin
         errors++;
         $display("FAIL drain_end valid %b empty %b count %0d exp 0 1 0",
                  pop_valid, empty, fifo_count);
      end
   endtask

   task automatic test_err();
      push_n(8, 4'd0);
      @(negedge clk);
      push = 1'b1;
      push_data = 4'd9;
      #1;
      checks++;
      if (push_ready !== 1'b0 || ram_en !== 1'b0) begin
         errors++;
         $display("FAIL err_full_push ready %b en %b exp 0 0",
                  push_ready, ram_en);
      end
      @(posedge clk); #1;
      checks++;
      if (fifo_count !== 4'd8 || err !== 1'b1) begin
         errors++;
         $display("FAIL err_full_state count %0d err %b exp 8 1",
                  fifo_count, err);
      end
      @(negedge clk);
      push = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_sticky got %b exp 1", err);
      end
      do_reset();
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL err_clear got %b exp 0", err);
      end
      @(negedge clk);
      pop = 1'b1;
      #1;
      checks++;
      if (pop_ready !== 1'b0 || ram_en !== 1'b0) begin
         errors++;
         $display("FAIL err_empty_pop ready %b en %b exp 0 0",
                  pop_ready, ram_en);
      end
      @(posedge clk); #1;
      checks++;
      if (fifo_count !== 4'd0 || err !== 1'b1 || pop_valid !== 1'b0) begin
         errors++;
         $display("FAIL err_empty_state count %0d err %b valid %b exp 0 1 0",
                  fifo_count, err, pop_valid);
      end
      @(negedge clk);
      pop = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      push_n(3, 4'd1);
      @(negedge clk);
      push = 1'b1;
      pop = 1'b1;
      push_data = 4'd4;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (push_ready !== 1'b0 || pop_ready !== 1'b1 || ram_rnw !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready push_rdy %b pop_rdy %b rnw %b exp 0 1 1",
                     push_ready, pop_ready, ram_rnw);
         end
         @(posedge clk); #1;
         checks++;
         if (fifo_count !== 4'(2 - i) || pop_valid !== 1'b1 ||
             pop_data !== 4'(1 + i)) begin
            errors++;
            $display("FAIL b2b_pop count %0d valid %b data %0d exp %0d 1 %0d",
                     fifo_count, pop_valid, pop_data, 2 - i, 1 + i);
         end
      end
      @(negedge clk);
      pop = 1'b0;
      #1;
      checks++;
      if (push_ready !== 1'b1 || ram_en !== 1'b1 || ram_address !== 3'd3) begin
         errors++;
         $display("FAIL b2b_push rdy %b en %b addr %0d exp 1 1 3",
                  push_ready, ram_en, ram_address);
      end
      @(posedge clk); #1;
      checks++;
      if (fifo_count !== 4'd2 || pop_valid !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end count %0d valid %b err %b exp 2 0 0",
                  fifo_count, pop_valid, err);
      end
      @(negedge clk);
      push = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      push_n(8, 4'd0);
      pop_n(5);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         push = 1'b1;
         push_data = 4'(8 + i);
         #1;
         checks++;
         if (ram_address !== 3'(i) || ram_rnw !== 1'b0) begin
            errors++;
            $display("FAIL wrap_push addr %0d rnw %b exp %0d 0",
                     ram_address, ram_rnw, i);
         end
      end
      @(negedge clk);
      push = 1'b0;
      checks++;
      if (fifo_count !== 4'd8 || full !== 1'b1) begin
         errors++;
         $display("FAIL wrap_full count %0d full %b exp 8 1", fifo_count, full);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         pop = 1'b1;
         #1;
         checks++;
         if (ram_address !== 3'((5 + i) % 8)) begin
            errors++;
            $display("FAIL wrap_rd_addr got %0d exp %0d",
                     ram_address, (5 + i) % 8);
         end
         @(posedge clk); #1;
         checks++;
         if (pop_valid !== 1'b1 || pop_data !== 4'(5 + i)) begin
            errors++;
            $display("FAIL wrap_data valid %b data %0d exp 1 %0d",
                     pop_valid, pop_data, 5 + i);
         end
      end
      @(negedge clk);
      pop = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (empty !== 1'b1) begin
         errors++; $display("FAIL wrap_empty got %b exp 1", empty);
      end
   endtask

   task automatic test_reset_after_pop();
      push_n(2, 4'd6);
      @(negedge clk);
      pop = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (pop_valid !== 1'b1 || pop_data !== 4'd6) begin
         errors++;
         $display("FAIL rap_pop valid %b data %0d exp 1 6", pop_valid, pop_data);
      end
      @(negedge clk);
      reset_L = 1'b0;
      #1;
      checks++;
      if (ram_en !== 1'b0) begin
         errors++; $display("FAIL rap_ram_en got %b exp 0", ram_en);
      end
      @(posedge clk); #1;
      checks++;
      if (pop_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 ||
          fifo_count !== 4'd0 || err !== 1'b0) begin
         errors++;
         $display("FAIL rap_flags valid %b empty %b full %b count %0d err %b exp 0 1 0 0 0",
                  pop_valid, empty, full, fifo_count, err);
      end
      @(negedge clk);
      pop = 1'b0;
      reset_L = 1'b1;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_err();
      test_back_to_back();
      test_wrap();
      test_reset_after_pop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
